// File: rtl/fmv_frame_queue_pkg.sv
// fmv_frame_queue_pkg
//   Shared types and helpers for the FMV frame buffer manager.
//   - planar_yuv_s : Y/U/V plane byte addresses (29-bit DDR byte space)
//   - buf_state_e  : lifecycle of one DDR frame buffer
//   - buffer_frame : plane addresses of buffer idx
//   Optional feature macro used by the manager: FMV_PACING_EN.
package fmv_frame_queue_pkg;

  typedef struct packed {
    logic [28:0] y;
    logic [28:0] u;
    logic [28:0] v;
  } planar_yuv_s;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WRITING = 2'd1,
    READY   = 2'd2,
    SHOWN   = 2'd3
  } buf_state_e;

  localparam int unsigned DEF_NUM_BUFFERS = 4;
  localparam logic [28:0] DEF_BASE_ADDR   = 29'h0100000;
  localparam logic [28:0] DEF_BUF_BYTES   = 29'h0020000;
  localparam logic [28:0] DEF_Y_BYTES     = 29'h0014000;
  localparam logic [28:0] DEF_C_BYTES     = 29'h0005000;

  // U follows Y, V follows U; all sums wrap in the 29-bit address space.
  function automatic planar_yuv_s buffer_frame(
    input logic [3:0]  idx,
    input logic [28:0] base_addr = DEF_BASE_ADDR,
    input logic [28:0] buf_bytes = DEF_BUF_BYTES,
    input logic [28:0] y_bytes   = DEF_Y_BYTES,
    input logic [28:0] c_bytes   = DEF_C_BYTES
  );
    planar_yuv_s f;
    f.y = base_addr + 29'(idx) * buf_bytes;
    f.u = f.y + y_bytes;
    f.v = f.u + c_bytes;
    return f;
  endfunction

endpackage

// File: rtl/fmv_frame_queue_if.sv
// fmv_frame_queue_if
//   Decoder / video-timing side bundle of the frame buffer manager.
//   master : decoder + vblank source (alloc_req, commit, flush, display_tick, frame_period)
//   slave  : fmv_frame_queue (grants, latch pulses, status)
interface fmv_frame_queue_if
  import fmv_frame_queue_pkg::*;
#(
  parameter int unsigned NUM_BUFFERS = DEF_NUM_BUFFERS
);
  localparam int unsigned IW = $clog2(NUM_BUFFERS);

  logic          alloc_req;
  logic          alloc_ack;
  planar_yuv_s   alloc_frame;
  logic [IW-1:0] alloc_idx;
  logic          commit;
  logic [IW-1:0] commit_idx;
  logic          flush;
  logic          display_tick;
  logic [3:0]    frame_period;
  logic          latch_frame;
  planar_yuv_s   frame;
  logic          invalidate_latched_frame;
  logic          show_on_next_video_frame;
  logic [IW:0]   queue_level;
  logic          commit_error;

  modport master (
    output alloc_req, commit, commit_idx, flush, display_tick, frame_period,
    input  alloc_ack, alloc_frame, alloc_idx, latch_frame, frame,
           invalidate_latched_frame, show_on_next_video_frame, queue_level, commit_error
  );

  modport slave (
    input  alloc_req, commit, commit_idx, flush, display_tick, frame_period,
    output alloc_ack, alloc_frame, alloc_idx, latch_frame, frame,
           invalidate_latched_frame, show_on_next_video_frame, queue_level, commit_error
  );

endinterface

// File: rtl/fmv_index_fifo.sv
// fmv_index_fifo
//   Synchronous FIFO of buffer indices (ready queue of committed frames).
//   clk, reset (sync, active-high), clear (drop contents)
//   push/push_idx, pop -> head/empty/level
//   Pop on an empty FIFO is ignored, so a same-cycle push+pop on empty leaves
//   the pushed entry for a later pop. Push on full is ignored.
module fmv_index_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 2,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [IW-1:0] push_idx,
  input  logic          pop,
  output logic [IW-1:0] head,
  output logic          empty,
  output logic [PW:0]   level
);
  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt;
  logic          pop_ok, push_ok;

  assign pop_ok  = pop && (cnt != '0);
  assign push_ok = push && ((cnt != (PW+1)'(DEPTH)) || pop_ok);
  assign head    = mem[rd_ptr];
  assign empty   = (cnt == '0);
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  end

  // Storage needs no reset; validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_idx;
  end

endmodule

// File: rtl/fmv_frame_queue.sv
// fmv_frame_queue
//   Frame buffer manager in the clkddr domain, upstream of the FMV player.
//   Hands out FREE DDR buffers to the decoder, queues committed frames FIFO,
//   releases one frame per display tick and recycles the previously shown one.
//   Ports:
//     clk    : clkddr
//     reset  : synchronous, active-high
//     bus    : fmv_frame_queue_if.slave (alloc, commit, flush, tick, latch, status)
//   Config: FMV_PACING_EN -- when defined, pops are spaced by at least
//   max(frame_period,1) ticks; when undefined, frame_period is ignored.
//   Same-cycle priority: flush > tick-release > commit > alloc.
module fmv_frame_queue
  import fmv_frame_queue_pkg::*;
#(
  parameter int unsigned NUM_BUFFERS = DEF_NUM_BUFFERS,
  parameter logic [28:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [28:0] BUF_BYTES   = DEF_BUF_BYTES,
  parameter logic [28:0] Y_BYTES     = DEF_Y_BYTES,
  parameter logic [28:0] C_BYTES     = DEF_C_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  fmv_frame_queue_if.slave  bus
);
  localparam int unsigned IW = $clog2(NUM_BUFFERS);

  buf_state_e    st_q [NUM_BUFFERS];
  buf_state_e    st_d [NUM_BUFFERS];
  logic          shown_vld_q, shown_vld_d;
  logic [IW-1:0] shown_idx_q, shown_idx_d;

  logic          fifo_empty;
  logic [IW-1:0] fifo_head;
  logic [IW:0]   fifo_level;

  logic          pace_ok;
  logic          pop;
  logic          commit_ok;
  logic          commit_bad;
  logic          grant;
  logic [IW-1:0] grant_idx;

  function automatic planar_yuv_s frame_of(input logic [IW-1:0] idx);
    return buffer_frame(4'(idx), BASE_ADDR, BUF_BYTES, Y_BYTES, C_BYTES);
  endfunction

`ifdef FMV_PACING_EN
  // Ticks since last pop, saturating so an empty queue keeps its credit.
  // Starts saturated so the first frame after reset/flush goes out at once.
  logic [3:0] tick_cnt_q;
  logic [3:0] elapsed;
  logic [3:0] period_eff;

  always_comb begin
    period_eff = (bus.frame_period == 4'd0) ? 4'd1 : bus.frame_period;
    elapsed    = (tick_cnt_q == 4'hF) ? 4'hF : tick_cnt_q + 4'd1;
    pace_ok    = (elapsed >= period_eff);
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush)    tick_cnt_q <= 4'hF;
    else if (bus.display_tick) tick_cnt_q <= pop ? 4'd0 : elapsed;
  end
`else
  // frame_period has no meaning without pacing.
  logic pace_unused;
  assign pace_unused = ^bus.frame_period;
  assign pace_ok     = 1'b1;
`endif

  always_comb begin
    st_d        = st_q;
    shown_vld_d = shown_vld_q;
    shown_idx_d = shown_idx_q;
    commit_ok   = 1'b0;
    commit_bad  = 1'b0;
    grant       = 1'b0;
    grant_idx   = '0;
    pop         = bus.display_tick && !bus.flush && !fifo_empty && pace_ok;

    if (bus.flush) begin
      for (int i = 0; i < int'(NUM_BUFFERS); i++) st_d[i] = FREE;
      shown_vld_d = 1'b0;
    end else begin
      if (pop) begin
        if (shown_vld_q) st_d[shown_idx_q] = FREE;
        st_d[fifo_head] = SHOWN;
        shown_vld_d     = 1'b1;
        shown_idx_d     = fifo_head;
      end
      // WRITING is untouched by the tick, so st_q is the right reference.
      if (bus.commit) begin
        if (st_q[bus.commit_idx] == WRITING) begin
          commit_ok              = 1'b1;
          st_d[bus.commit_idx]   = READY;
        end else begin
          commit_bad = 1'b1;
        end
      end
      // Search post-tick state so a buffer freed by this tick is grantable.
      if (bus.alloc_req) begin
        for (int i = int'(NUM_BUFFERS) - 1; i >= 0; i--) begin
          if (st_d[i] == FREE) begin
            grant     = 1'b1;
            grant_idx = IW'(i);
          end
        end
      end
      if (grant) st_d[grant_idx] = WRITING;
    end
  end

  fmv_index_fifo #(
    .DEPTH (NUM_BUFFERS),
    .IW    (IW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.flush),
    .push     (commit_ok),
    .push_idx (bus.commit_idx),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign bus.queue_level = fifo_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_BUFFERS); i++) st_q[i] <= FREE;
      shown_vld_q                  <= 1'b0;
      shown_idx_q                  <= '0;
      bus.alloc_ack                <= 1'b0;
      bus.alloc_idx                <= '0;
      bus.alloc_frame              <= '0;
      bus.latch_frame              <= 1'b0;
      bus.frame                    <= '0;
      bus.invalidate_latched_frame <= 1'b0;
      bus.show_on_next_video_frame <= 1'b0;
      bus.commit_error             <= 1'b0;
    end else begin
      st_q        <= st_d;
      shown_vld_q <= shown_vld_d;
      shown_idx_q <= shown_idx_d;

      bus.alloc_ack <= grant;
      if (grant) begin
        bus.alloc_idx   <= grant_idx;
        bus.alloc_frame <= frame_of(grant_idx);
      end

      bus.latch_frame <= pop;
      if (pop) bus.frame <= frame_of(fifo_head);

      bus.invalidate_latched_frame <= bus.flush;
      if (bus.flush)  bus.show_on_next_video_frame <= 1'b0;
      else if (pop)   bus.show_on_next_video_frame <= 1'b1;

      if (commit_bad) bus.commit_error <= 1'b1;
    end
  end

endmodule
